// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding and default baud divisor.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int BAUD_DIV_DEFAULT = 2604;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the synchronised value.
// All flops reset to 1 so an idle-high line never produces a spurious edge out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic rx_meta;
   logic rx_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver, LSB first, mid-bit sampling with a BAUD_DIV clock divider.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects sense).
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 frm_err,
   output logic                 par_err,
   output logic                 ovr_err
);

   localparam int CNT_W = $clog2(BAUD_DIV + 1);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

   if (BAUD_DIV < 16 || BAUD_DIV > 8191 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx_cfg: parameter out of legal range");
   end

   logic rx_s;
   logic fall;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (RX),
      .rx_s  (rx_s),
      .fall  (fall)
   );

   rx_state_t            state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_bad;
   logic                 done;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction
`endif

   // Frame FSM: the counter restarts at every sample so each sample lands one bit later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         stop_bad <= 1'b0;
         done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state    <= ST_START;
                  baud_cnt <= '0;
               end
            end
            ST_START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt <= '0;
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt <= '0;
                  par_bad  <= rx_s ^ parity_bit(shreg);
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt <= '0;
                  stop_bad <= ~rx_s;
                  done     <= 1'b1;
                  state    <= rx_s ? ST_IDLE : ST_BREAK;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Result registers: a completing frame wins over clr_rdy in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data <= '0;
         rdy     <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
      end else if (done) begin
         rx_data <= shreg;
         frm_err <= stop_bad;
         rdy     <= 1'b1;
         if (clr_rdy)  ovr_err <= 1'b0;
         else if (rdy) ovr_err <= 1'b1;
      end else if (clr_rdy) begin
         rdy     <= 1'b0;
         ovr_err <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    par_err <= 1'b0;
      else if (done) par_err <= par_bad;
   end
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with a frame-level reference model checked every cycle.
// Works in both builds (with or without UART_RX_PARITY_EN).
module tb_uart_rx_cfg;

   localparam int B       = 32;
   localparam int HALF    = B / 2;
   localparam int DB      = 8;
   localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int NP      = 1;
   localparam int LAT_LIT = 340;
   localparam int PE_BAD  = 1;
`else
   localparam int NP      = 0;
   localparam int LAT_LIT = 308;
   localparam int PE_BAD  = 0;
`endif
   // Bits before the stop bit, and RX-fall to rdy-set delay in clocks
   localparam int F   = DB + 1 + NP;
   localparam int LAT = 4 + HALF + F * B;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy, frm_err, par_err, ovr_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rise_cyc = 0;
   bit chk_en = 1'b0;
   logic rdy_q = 1'b0;

   typedef struct {
      int         at;
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } ev_t;
   ev_t evq[$];

   logic [7:0] m_data = '0;
   logic       m_rdy = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;

   uart_rx_cfg #(.BAUD_DIV(B), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .par_err (par_err),
      .ovr_err (ovr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: each queued frame completes at a known cycle; clr_rdy handled by rule.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data <= '0;
         m_rdy  <= 1'b0;
         m_fe   <= 1'b0;
         m_pe   <= 1'b0;
         m_ovr  <= 1'b0;
         evq.delete();
      end else begin
         cyc <= cyc + 1;
         if (evq.size() > 0 && evq[0].at == cyc + 1) begin
            m_rdy  <= 1'b1;
            m_data <= evq[0].d;
            m_fe   <= evq[0].fe;
            m_pe   <= evq[0].pe;
            if (clr_rdy)    m_ovr <= 1'b0;
            else if (m_rdy) m_ovr <= 1'b1;
            evq.delete(0);
         end else if (clr_rdy) begin
            m_rdy <= 1'b0;
            m_ovr <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("rx_data", 32'(rx_data), 32'(m_data));
         check("rdy", 32'(rdy), 32'(m_rdy));
         check("frm_err", 32'(frm_err), 32'(m_fe));
         check("par_err", 32'(par_err), 32'(m_pe));
         check("ovr_err", 32'(ovr_err), 32'(m_ovr));
         if (rdy === 1'b1 && rdy_q === 1'b0) rise_cyc <= cyc;
         rdy_q <= rdy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) tick();
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      tick();
      clr_rdy = 1'b0;
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ PAR_ODD;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_v,
                             input int stop_len, input bit clr_at_done, output int k);
      logic [11:0] bits;
      ev_t         e;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
      bits[DB + 1] = pbit;
      e.pe = (pbit != good_par(d));
`else
      e.pe = 1'b0;
`endif
      k    = cyc;
      e.at = k + LAT;
      e.d  = d;
      e.fe = ~stop_v;
      evq.push_back(e);
      for (int i = 0; i < F; i++) begin
         RX = bits[i];
         repeat (B) begin
            clr_rdy = clr_at_done && (cyc == e.at - 1);
            tick();
         end
      end
      RX = stop_v;
      repeat (stop_len) begin
         clr_rdy = clr_at_done && (cyc == e.at - 1);
         tick();
      end
      clr_rdy = 1'b0;
      RX = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset_rdy", 32'(rdy), 0);
      check("reset_data", 32'(rx_data), 0);
      check("reset_ovr", 32'(ovr_err), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      idle(4);

      // Good frame and its latency
      send_frame(8'hA5, good_par(8'hA5), 1'b1, B, 1'b0, k);
      check("a5_data", 32'(rx_data), 'hA5);
      check("a5_rdy", 32'(rdy), 1);
      check("a5_frm", 32'(frm_err), 0);
      check("a5_latency", 32'(rise_cyc - k), LAT_LIT);
      pulse_clr();
      check("clr_rdy", 32'(rdy), 0);

      // Glitch shorter than half a bit: false start, no output change
      RX = 1'b0;
      repeat (10) tick();
      idle(3 * B);
      check("glitch_rdy", 32'(rdy), 0);
      send_frame(8'h5A, good_par(8'h5A), 1'b1, B, 1'b0, k);
      check("5a_data", 32'(rx_data), 'h5A);
      pulse_clr();

      // Framing error with line held low (break), then recovery
      send_frame(8'h3C, good_par(8'h3C), 1'b0, 5 * B, 1'b0, k);
      check("brk_rdy", 32'(rdy), 1);
      check("brk_frm", 32'(frm_err), 1);
      check("brk_data", 32'(rx_data), 'h3C);
      idle(2 * B);
      pulse_clr();
      send_frame(8'h96, good_par(8'h96), 1'b1, B, 1'b0, k);
      check("96_frm", 32'(frm_err), 0);
      check("96_data", 32'(rx_data), 'h96);

      // Overrun
      pulse_clr();
      send_frame(8'h11, good_par(8'h11), 1'b1, B, 1'b0, k);
      send_frame(8'h22, good_par(8'h22), 1'b1, B, 1'b0, k);
      check("ovr_data", 32'(rx_data), 'h22);
      check("ovr_set", 32'(ovr_err), 1);
      pulse_clr();
      check("ovr_clr_rdy", 32'(rdy), 0);
      check("ovr_clr", 32'(ovr_err), 0);

      // Completion and clr_rdy in the same cycle while rdy already set
      send_frame(8'h44, good_par(8'h44), 1'b1, B, 1'b0, k);
      send_frame(8'h33, good_par(8'h33), 1'b1, B, 1'b1, k);
      check("setclr_rdy", 32'(rdy), 1);
      check("setclr_ovr", 32'(ovr_err), 0);
      check("setclr_data", 32'(rx_data), 'h33);

      // Parity sense (even): 0x07 needs parity bit 1
      pulse_clr();
      send_frame(8'h07, 1'b0, 1'b1, B, 1'b0, k);
      check("par_bad", 32'(par_err), PE_BAD);
      pulse_clr();
      send_frame(8'h07, 1'b1, 1'b1, B, 1'b0, k);
      check("par_good", 32'(par_err), 0);

      // Reset in the middle of frame 0xFF
      RX = 1'b0;
      repeat (B) tick();
      RX = 1'b1;
      repeat (3 * B + HALF) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", 32'(rdy), 0);
      check("mid_rst_data", 32'(rx_data), 0);
      check("mid_rst_par", 32'(par_err), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      idle(2 * B);
      send_frame(8'h81, good_par(8'h81), 1'b1, B, 1'b0, k);
      check("81_data", 32'(rx_data), 'h81);
      check("81_rdy", 32'(rdy), 1);
      check("81_ovr", 32'(ovr_err), 0);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200); legal range 16..8191.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_ODD, default 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 RX  input  1  asynchronous serial line, idle high, LSB first.
REQ-007 clr_rdy  input  1  pulse; clears rdy and ovr_err.
REQ-008 rx_data  output  DATA_BITS  last received data word.
REQ-009 rdy  output  1  received word valid.
REQ-010 frm_err  output  1  stop bit of last frame sampled low.
REQ-011 par_err  output  1  parity mismatch on last frame.
REQ-012 ovr_err  output  1  sticky; a frame completed while rdy was still set.

Function
REQ-013 RX SHALL pass through two synchroniser flops, both reset to 1; start detection is a 1-to-0 transition on the synchronised line, in IDLE only.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE->START on start detection; baud counter cleared.
REQ-016 START: sample at BAUD_DIV/2 (integer division); line low -> DATA, line high -> IDLE (false start, no output change).
REQ-017 DATA: sample every BAUD_DIV clocks at bit midpoints; shift LSB first; after DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-018 PARITY: one sample BAUD_DIV clocks later; mismatch vs computed parity of data bits per PARITY_ODD -> par_err for this frame.
REQ-019 STOP: one sample BAUD_DIV clocks later; the following cycle rx_data, frm_err and par_err load together and rdy sets.
REQ-020 Stop sampled high -> IDLE; stop sampled low -> frm_err=1, BREAK; BREAK -> IDLE when synchronised line is high.
REQ-021 frm_err and par_err SHALL reflect only the most recent frame and change only at the rdy-set cycle.
REQ-022 rdy set and clr_rdy in the same cycle: set wins; ovr_err is not set.
REQ-023 Frame completion while rdy=1 and clr_rdy=0: ovr_err=1, rx_data overwritten with new word.
REQ-024 clr_rdy with no completion: rdy=0, ovr_err=0, next cycle.
REQ-025 Baud counter width SHALL be $clog2(BAUD_DIV+1); bit counter width $clog2(DATA_BITS+1); no wrap within a frame.
REQ-026 Line activity in START/DATA/PARITY/STOP SHALL NOT restart the frame.

Reset
REQ-027 rst_n low at any time, including mid-frame: state IDLE, counters 0, rx_data 0, rdy/frm_err/par_err/ovr_err 0, synchronisers 1; partial frame discarded.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, frame = start + DATA_BITS + parity + stop.
REQ-029 Macro undefined: no PARITY state or parity logic, frame = start + DATA_BITS + stop, par_err tied 0; PARITY_ODD ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the rx state enum and the default BAUD_DIV constant 2604.
REQ-031 Sub-module uart_rx_sync SHALL hold the two-flop synchroniser and falling-edge detect, outputs rx_s and fall.

Verification (BAUD_DIV=2604, DATA_BITS=8)
REQ-032 Frame 0xA5, good stop -> rx_data=0xA5, rdy rises 9*2604+1302 (+sync/2 register) clocks after RX falls, frm_err=0.
REQ-033 RX low for 1000 clocks then high -> no rdy, FSM returns to IDLE at 1302-clock sample.
REQ-034 Frame 0x3C with stop bit low, RX held low 5 bit times -> rdy=1, frm_err=1, no new frame until RX high.
REQ-035 Frames 0x11 then 0x22, no clr_rdy -> rx_data=0x22, ovr_err=1; clr_rdy pulse -> rdy=0, ovr_err=0.
REQ-036 UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 -> par_err=1; parity bit 1 -> par_err=0.
REQ-037 rst_n pulsed low at data bit 4 of frame 0xFF -> all outputs 0; next full frame 0x81 received correctly.
